sample_memory_mc: RTL
=====================

Name: sample_memory_mc

Overview:
Multi-channel circular sample capture memory, the next generation of the IAGC sample store. It holds NUM_CHANNELS parallel channels of DATA_SIZE samples over a programmable depth. Capture, dump, clean and set-size are driven by a command handshake rather than by decoding the IAGC status. Captured data is streamed out oldest-first on a valid/ready port.

Parameters:
DATA_SIZE, 16, sample width in bits
ADDR_SIZE, 12, address width
DEPTH, 4096, physical entries per channel; must be at most 2**ADDR_SIZE
NUM_CHANNELS, 2, number of parallel channels (minimum 1)
CH_SEL_SIZE, 1, width of the channel select; must be at least clog2(NUM_CHANNELS)

Ports:
i_clock  in  1  system clock, all logic on rising edge
i_reset_n  in  1  reset, asynchronous, active-low
i_cmd_valid  in  1  command strobe
i_cmd  in  3  command code: 0 STOP, 1 CAPTURE, 2 DUMP, 3 CLEAN, 4 SET_SIZE; 5-7 reserved
i_cmd_arg  in  ADDR_SIZE+1  memory size, used by SET_SIZE only
o_cmd_ready  out  1  command accepted when i_cmd_valid and o_cmd_ready are both high
i_sample_valid  in  1  sample strobe
i_samples  in  NUM_CHANNELS*DATA_SIZE  channel k occupies bits [k*DATA_SIZE +: DATA_SIZE]
i_dump_channel  in  CH_SEL_SIZE  channel to dump, sampled when DUMP is accepted
o_data  out  DATA_SIZE  dump data
o_data_valid  out  1  dump beat valid
i_data_ready  in  1  downstream accepts the dump beat
o_data_last  out  1  final dump beat, qualified by o_data_valid
o_clean_done  out  1  one-cycle pulse when a clean completes
o_busy  out  1  state is not IDLE
o_state  out  2  current state: 0 IDLE, 1 CAPTURE, 2 DUMP, 3 CLEAN
o_sample_count  out  ADDR_SIZE+1  number of valid stored entries
o_wrapped  out  1  capture has overwritten at least one entry

Behaviour:
- Reset values: state IDLE, wr_ptr 0, sample_count 0, wrapped 0, mem_size DEPTH. o_data=0, o_data_valid=0, o_data_last=0, o_clean_done=0. RAM contents are not reset.
- Reset asserted mid-operation aborts the operation immediately and forces all reset values. RAM keeps its contents.
- o_cmd_ready is high in IDLE and in CAPTURE; it is low in DUMP and CLEAN.
  - In CAPTURE only STOP has an effect; every other accepted code is ignored.
  - Reserved codes, and STOP in IDLE, are accepted and ignored.
- SET_SIZE (IDLE only): mem_size <= (arg==0 || arg>DEPTH) ? DEPTH : arg. It also clears wr_ptr, sample_count and wrapped.
- CAPTURE accept: clear wr_ptr, sample_count and wrapped, then go to CAPTURE.
  - Each i_sample_valid writes every channel at wr_ptr.
  - wr_ptr <= (wr_ptr == mem_size-1) ? 0 : wr_ptr+1.
  - sample_count increments and saturates at mem_size.
  - wrapped sets on the first write that occurs while sample_count == mem_size.
- STOP in CAPTURE: go to IDLE next cycle. An i_sample_valid in the same cycle is still written.
- DUMP accept:
  - Latch i_dump_channel. Read start address = wrapped ? wr_ptr : 0. Beats = sample_count.
  - If sample_count == 0: return to IDLE with no beats.
  - Synchronous RAM read has 1-cycle latency. The first o_data_valid appears 2 cycles after acceptance.
  - Beats follow address order with wrap at mem_size-1 back to 0.
  - o_data, o_data_valid and o_data_last are held stable while i_data_ready is low. Sustained throughput is 1 beat/cycle while ready stays high (prefetch or skid register required).
  - o_data_last is high on beat sample_count-1. After that beat is accepted, return to IDLE; o_data_valid=0 next cycle.
  - Channel select >= NUM_CHANNELS: beats are still produced, with o_data=0.
  - Dump does not modify wr_ptr, sample_count or wrapped.
- CLEAN accept:
  - Write 0 to all channels at addresses 0..mem_size-1, one address per cycle, taking mem_size cycles.
  - o_clean_done pulses for 1 cycle the cycle after the last write; the block is in IDLE that same cycle.
  - Clears wr_ptr, sample_count and wrapped.
  - Entries at or above mem_size are untouched.
- o_busy = (state != IDLE). o_sample_count and o_wrapped are registered.

Test Plan:
- Reset, then CAPTURE with 5 samples (ch0 = 1..5, ch1 = 0x100..0x104), STOP, DUMP ch1 with ready held high -> o_sample_count=5. Beats 0x100..0x104 on 5 consecutive cycles starting 2 cycles after DUMP accept; o_data_last on 0x104.
- SET_SIZE 4, capture 6 samples 10..15 on ch0, DUMP ch0 -> count=4, wrapped=1, beats 12,13,14,15.
- Dump with i_data_ready toggling 1010..., 3 entries stored -> no beat lost or duplicated. o_data held while ready is low; exactly 3 handshakes.
- SET_SIZE 8, CLEAN -> o_busy high for 8 cycles, o_clean_done pulse, then DUMP returns no beats (count 0). Capture 8 entries without writing any sample values; a dump shows the 8 zeroed entries.
- SET_SIZE 0 and SET_SIZE DEPTH+1 -> mem_size=DEPTH; capture DEPTH+1 samples -> count=DEPTH, wrapped=1.
- Deassert i_reset_n mid-DUMP after 2 beats -> o_data_valid=0 asynchronously, state IDLE, count 0; a following DUMP produces no beats.

Source files
------------

// File: rtl/sample_memory_mc.sv
// Multi-channel circular sample capture memory with command handshake and
// an oldest-first valid/ready dump port. Command encoding: 0 STOP,
// 1 CAPTURE, 2 DUMP, 3 CLEAN, 4 SET_SIZE; 5-7 are accepted and ignored.
//
// state   | meaning
// IDLE    | waiting for a command
// CAPTURE | every i_sample_valid writes all channels at wr_ptr
// DUMP    | streaming stored entries oldest-first
// CLEAN   | zeroing addresses 0..mem_size-1, one per cycle
module sample_memory_mc #(
  parameter int DATA_SIZE    = 16,
  parameter int ADDR_SIZE    = 12,
  parameter int DEPTH        = 4096,
  parameter int NUM_CHANNELS = 2,
  parameter int CH_SEL_SIZE  = 1
) (
  input  logic                              i_clock,
  input  logic                              i_reset_n,
  input  logic                              i_cmd_valid,
  input  logic [2:0]                        i_cmd,
  input  logic [ADDR_SIZE:0]                i_cmd_arg,
  output logic                              o_cmd_ready,
  input  logic                              i_sample_valid,
  input  logic [NUM_CHANNELS*DATA_SIZE-1:0] i_samples,
  input  logic [CH_SEL_SIZE-1:0]            i_dump_channel,
  output logic [DATA_SIZE-1:0]              o_data,
  output logic                              o_data_valid,
  input  logic                              i_data_ready,
  output logic                              o_data_last,
  output logic                              o_clean_done,
  output logic                              o_busy,
  output logic [1:0]                        o_state,
  output logic [ADDR_SIZE:0]                o_sample_count,
  output logic                              o_wrapped
);

  localparam int CW = NUM_CHANNELS * DATA_SIZE;
  localparam logic [ADDR_SIZE:0] DEPTH_W = (ADDR_SIZE+1)'(DEPTH);
  localparam logic [2:0] CMD_STOP = 3'd0, CMD_CAPTURE = 3'd1, CMD_DUMP = 3'd2,
                         CMD_CLEAN = 3'd3, CMD_SET_SIZE = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DUMP    = 2'd2,
    ST_CLEAN   = 2'd3
  } state_t;

  state_t                   state, state_nxt;
  logic [ADDR_SIZE:0]       mem_size, sample_count, last_addr;
  logic [ADDR_SIZE-1:0]     wr_ptr, clean_addr, rd_addr, rd_addr_c;
  logic                     wrapped;
  logic [ADDR_SIZE:0]       issue_left, issue_cnt_c;
  logic                     rd_pend, rd_pend_last;
  logic [CH_SEL_SIZE-1:0]   dump_ch;
  logic [DATA_SIZE-1:0]     skid_data, ram_ch;
  logic                     skid_valid, skid_last;
  logic [CW-1:0]            mem [DEPTH];
  logic [CW-1:0]            ram_q;

  logic cmd_fire, idle_fire, dump_start, pop, issue_dump, rd_issue;
  logic cap_we, clean_we, we, clean_end;
  logic [1:0] occ;
  logic [ADDR_SIZE-1:0] waddr;
  logic [CW-1:0] wdata;

  function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a,
                                                     input logic [ADDR_SIZE:0] last);
    return ({1'b0, a} == last) ? '0 : a + 1'b1;
  endfunction

  assign o_cmd_ready = (state == ST_IDLE) || (state == ST_CAPTURE);
  assign o_busy      = (state != ST_IDLE);
  assign o_state     = state;
  assign o_sample_count = sample_count;
  assign o_wrapped   = wrapped;

  assign cmd_fire   = i_cmd_valid && o_cmd_ready;
  assign idle_fire  = cmd_fire && (state == ST_IDLE);
  assign last_addr  = mem_size - 1'b1;
  assign dump_start = idle_fire && (i_cmd == CMD_DUMP) && (sample_count != '0);
  assign pop        = o_data_valid && i_data_ready;

  // Reads are only issued while the output register, skid register and the
  // in-flight RAM read together leave room for the returning word.
  assign occ        = {1'b0, o_data_valid} + {1'b0, skid_valid} + {1'b0, rd_pend};
  assign issue_dump = (state == ST_DUMP) && (issue_left != '0) &&
                      ((occ < 2'd2) || (pop && (occ == 2'd2)));
  assign rd_issue   = dump_start || issue_dump;
  assign rd_addr_c  = dump_start ? (wrapped ? wr_ptr : '0) : rd_addr;
  assign issue_cnt_c = dump_start ? sample_count : issue_left;

  assign cap_we    = (state == ST_CAPTURE) && i_sample_valid;
  assign clean_we  = (state == ST_CLEAN);
  assign clean_end = clean_we && ({1'b0, clean_addr} == last_addr);
  assign we        = cap_we || clean_we;
  assign waddr     = clean_we ? clean_addr : wr_ptr;
  assign wdata     = clean_we ? '0 : i_samples;

  always_ff @(posedge i_clock) begin
    if (we) mem[waddr] <= wdata;
    if (rd_issue) ram_q <= mem[rd_addr_c];
  end

  always_comb begin
    ram_ch = '0;
    for (int k = 0; k < NUM_CHANNELS; k++)
      if (dump_ch == CH_SEL_SIZE'(k)) ram_ch = ram_q[k*DATA_SIZE +: DATA_SIZE];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:
        if (cmd_fire) begin
          case (i_cmd)
            CMD_CAPTURE: state_nxt = ST_CAPTURE;
            CMD_DUMP:    state_nxt = (sample_count != '0) ? ST_DUMP : ST_IDLE;
            CMD_CLEAN:   state_nxt = ST_CLEAN;
            default:     state_nxt = ST_IDLE;
          endcase
        end
      ST_CAPTURE: if (cmd_fire && (i_cmd == CMD_STOP)) state_nxt = ST_IDLE;
      ST_DUMP:    if (pop && o_data_last) state_nxt = ST_IDLE;
      ST_CLEAN:   if (clean_end) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state        <= ST_IDLE;
      mem_size     <= DEPTH_W;
      wr_ptr       <= '0;
      sample_count <= '0;
      wrapped      <= 1'b0;
      clean_addr   <= '0;
      o_clean_done <= 1'b0;
      dump_ch      <= '0;
      rd_addr      <= '0;
      issue_left   <= '0;
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
    end else begin
      state        <= state_nxt;
      o_clean_done <= clean_end;
      rd_pend      <= rd_issue;
      rd_pend_last <= rd_issue && (issue_cnt_c == (ADDR_SIZE+1)'(1));
      if (idle_fire) begin
        case (i_cmd)
          CMD_SET_SIZE: begin
            mem_size     <= ((i_cmd_arg == '0) || (i_cmd_arg > DEPTH_W)) ? DEPTH_W : i_cmd_arg;
            wr_ptr       <= '0;
            sample_count <= '0;
            wrapped      <= 1'b0;
          end
          CMD_CAPTURE, CMD_CLEAN: begin
            wr_ptr       <= '0;
            sample_count <= '0;
            wrapped      <= 1'b0;
            clean_addr   <= '0;
          end
          CMD_DUMP: dump_ch <= i_dump_channel;
          default: ;
        endcase
      end
      if (cap_we) begin
        wr_ptr <= next_addr(wr_ptr, last_addr);
        if (sample_count != mem_size) sample_count <= sample_count + 1'b1;
        else wrapped <= 1'b1;
      end
      if (clean_we) clean_addr <= clean_addr + 1'b1;
      if (rd_issue) begin
        rd_addr    <= next_addr(rd_addr_c, last_addr);
        issue_left <= issue_cnt_c - 1'b1;
      end
    end
  end

  // Output register backed by a one-entry skid so ready can drop at any time.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_data       <= '0;
      o_data_valid <= 1'b0;
      o_data_last  <= 1'b0;
      skid_data    <= '0;
      skid_valid   <= 1'b0;
      skid_last    <= 1'b0;
    end else if (rd_pend) begin
      if (!o_data_valid || pop) begin
        if (skid_valid) begin
          o_data      <= skid_data;
          o_data_last <= skid_last;
          skid_data   <= ram_ch;
          skid_last   <= rd_pend_last;
        end else begin
          o_data      <= ram_ch;
          o_data_last <= rd_pend_last;
        end
        o_data_valid <= 1'b1;
      end else begin
        skid_data  <= ram_ch;
        skid_last  <= rd_pend_last;
        skid_valid <= 1'b1;
      end
    end else if (pop) begin
      o_data       <= skid_data;
      o_data_valid <= skid_valid;
      o_data_last  <= skid_valid && skid_last;
      skid_valid   <= 1'b0;
    end
  end

endmodule
